// File: rtl/send_ins_if.sv
// Outbound write-queue link: byte, push strobe and the queue-full back-pressure flag.
interface send_ins_if;
    logic [7:0] out_write;
    logic       pp_write;
    logic       fu_write;

    modport master (output out_write, output pp_write, input fu_write);
    modport slave  (input out_write, input pp_write, output fu_write);
endinterface

// File: rtl/send_ins.sv
// Transmit-side packet encoder: buffers ADC samples and digital snapshots and
// emits each one as a two-byte packet (header, payload) into the write queue.
module send_ins #(
    parameter logic [2:0] ANALOG_P  = 3'b010,
    parameter logic [2:0] DIGITAL_P = 3'b001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  activemods,
    input  logic [11:0] adc0_data,
    input  logic        adc0_valid,
    input  logic [11:0] adc1_data,
    input  logic        adc1_valid,
    input  logic [7:0]  din,
    input  logic        din_tick,
    send_ins_if.master  wq,
    output logic [2:0]  overrun,
    input  logic        clr_ovr
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] PAY  = 2'd2;

    logic [1:0]  state;
    logic [15:0] word;
    logic [15:0] word_next;
    logic [11:0] adc0_buf;
    logic [11:0] adc1_buf;
    logic [7:0]  din_buf;
    logic [2:0]  pending;
    logic [2:0]  latch;
    logic [2:0]  strobe;
    logic [2:0]  en;
    logic        unused_mods;

    // Source index order everywhere: [0] digital, [1] ADC0, [2] ADC1.
    assign strobe      = {adc1_valid, adc0_valid, din_tick};
    assign en          = activemods[2:0];
    assign unused_mods = ^activemods[4:3];

    always_comb begin
        latch     = 3'b000;
        word_next = 16'h0000;
        if (state == IDLE) begin
            if (pending[1]) begin
                latch[1]  = 1'b1;
                word_next = {ANALOG_P, 1'b0, adc0_buf};
            end else if (pending[2]) begin
                latch[2]  = 1'b1;
                word_next = {ANALOG_P, 1'b1, adc1_buf};
            end else if (pending[0]) begin
                latch[0]  = 1'b1;
                word_next = {DIGITAL_P, 5'b00000, din_buf};
            end
        end
    end

    // A new strobe always re-arms pending, even on the edge its old value is latched.
    always_ff @(posedge clk) begin
        if (rst) begin
            adc0_buf <= 12'h000;
            adc1_buf <= 12'h000;
            din_buf  <= 8'h00;
            pending  <= 3'b000;
            overrun  <= 3'b000;
        end else begin
            if (adc0_valid && en[1]) adc0_buf <= adc0_data;
            if (adc1_valid && en[2]) adc1_buf <= adc1_data;
            if (din_tick && en[0])   din_buf  <= din;
            for (int i = 0; i < 3; i++) begin
                if (strobe[i] && en[i])
                    pending[i] <= 1'b1;
                else if (!en[i] || latch[i])
                    pending[i] <= 1'b0;

                if (strobe[i] && en[i] && pending[i] && !latch[i])
                    overrun[i] <= 1'b1;
                else if (clr_ovr)
                    overrun[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            word         <= 16'h0000;
            wq.pp_write  <= 1'b0;
            wq.out_write <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    wq.pp_write <= 1'b0;
                    if (|latch) begin
                        word  <= word_next;
                        state <= HDR;
                    end
                end
                HDR: begin
                    if (!wq.fu_write) begin
                        wq.pp_write  <= 1'b1;
                        wq.out_write <= word[15:8];
                        state        <= PAY;
                    end else begin
                        wq.pp_write <= 1'b0;
                    end
                end
                PAY: begin
                    if (!wq.fu_write) begin
                        wq.pp_write  <= 1'b1;
                        wq.out_write <= word[7:0];
                        state        <= IDLE;
                    end else begin
                        wq.pp_write <= 1'b0;
                    end
                end
                default: begin
                    wq.pp_write <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_send_ins.sv
// Self-checking bench for send_ins: table-driven single packets plus hand-written
// sequences for latency, stalls, overrun, enable drop and mid-packet reset.
module tb_send_ins;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  activemods;
    logic [11:0] adc0_data;
    logic        adc0_valid;
    logic [11:0] adc1_data;
    logic        adc1_valid;
    logic [7:0]  din;
    logic        din_tick;
    logic        clr_ovr;
    logic [2:0]  overrun;

    send_ins_if wq();

    send_ins dut (
        .clk        (clk),
        .rst        (rst),
        .activemods (activemods),
        .adc0_data  (adc0_data),
        .adc0_valid (adc0_valid),
        .adc1_data  (adc1_data),
        .adc1_valid (adc1_valid),
        .din        (din),
        .din_tick   (din_tick),
        .wq         (wq),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic [11:0] data;
        logic [7:0]  exp_hdr;
        logic [7:0]  exp_pay;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] sb [$];
    int         checks     = 0;
    int         failures   = 0;
    int         push_count = 0;
    int         base;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // src: 0 digital, 1 ADC0, 2 ADC1; strobe is held for exactly one edge.
    task automatic apply_stimulus(input logic [1:0] src, input logic [11:0] data);
        case (src)
            2'd0: begin din = data[7:0]; din_tick = 1'b1; end
            2'd1: begin adc0_data = data; adc0_valid = 1'b1; end
            default: begin adc1_data = data; adc1_valid = 1'b1; end
        endcase
        tick();
        din_tick   = 1'b0;
        adc0_valid = 1'b0;
        adc1_valid = 1'b0;
    endtask

    task automatic expect_bytes(input logic [7:0] hdr, input logic [7:0] pay);
        sb.push_back(hdr);
        sb.push_back(pay);
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n = 0;
        while ((sb.size() != 0 || wq.pp_write !== 1'b0) && n < max_cycles) begin
            tick();
            n++;
        end
        check_output(name, sb.size(), 0);
    endtask

    task automatic check_push(input string name, input logic [7:0] exp_byte);
        check_output({name, "_pp"}, wq.pp_write, 1'b1);
        check_output({name, "_byte"}, wq.out_write, exp_byte);
    endtask

    // Scoreboard monitor: every push must match the oldest outstanding byte.
    always @(negedge clk) begin
        if (wq.pp_write === 1'b1) begin
            push_count++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_push: got byte 0x%0h with no byte expected", wq.out_write);
            end else begin
                check_output("push_byte", wq.out_write, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{2'd1, 12'h000, 8'h40, 8'h00};
        vecs[1] = '{2'd1, 12'hFFF, 8'h4F, 8'hFF};
        vecs[2] = '{2'd2, 12'hA5C, 8'h5A, 8'h5C};
        vecs[3] = '{2'd2, 12'h001, 8'h50, 8'h01};
        vecs[4] = '{2'd0, 12'h03C, 8'h20, 8'h3C};
        vecs[5] = '{2'd0, 12'h0FF, 8'h20, 8'hFF};
        vecs[6] = '{2'd0, 12'h000, 8'h20, 8'h00};

        rst         = 1'b1;
        activemods  = 5'b00000;
        adc0_data   = 12'h000;
        adc0_valid  = 1'b0;
        adc1_data   = 12'h000;
        adc1_valid  = 1'b0;
        din         = 8'h00;
        din_tick    = 1'b0;
        clr_ovr     = 1'b0;
        wq.fu_write = 1'b0;
        tick();
        tick();
        check_output("reset_pp", wq.pp_write, 1'b0);
        check_output("reset_out", wq.out_write, 8'h00);
        check_output("reset_ovr", overrun, 3'b000);
        rst = 1'b0;
        tick();

        // Basic ADC0 packet with cycle-exact latency.
        $display("[TB] single ADC0 packet latency");
        activemods = 5'b00010;
        base = push_count;
        expect_bytes(8'h4A, 8'h5C);
        apply_stimulus(2'd1, 12'hA5C);
        check_output("lat_e0_pp", wq.pp_write, 1'b0);
        tick();
        check_output("lat_e1_pp", wq.pp_write, 1'b0);
        tick();
        check_push("lat_e2", 8'h4A);
        tick();
        check_push("lat_e3", 8'h5C);
        tick();
        check_output("lat_e4_pp", wq.pp_write, 1'b0);
        check_output("lat_count", push_count - base, 2);
        check_output("lat_ovr", overrun, 3'b000);

        $display("[TB] table-driven packets");
        activemods = 5'b00111;
        for (int i = 0; i < 7; i++) begin
            expect_bytes(vecs[i].exp_hdr, vecs[i].exp_pay);
            apply_stimulus(vecs[i].src, vecs[i].data);
            wait_drain("table_drain", 20);
            check_output("table_ovr", overrun, 3'b000);
        end

        $display("[TB] simultaneous strobes, priority order");
        din        = 8'h3C;
        din_tick   = 1'b1;
        adc0_data  = 12'h123;
        adc0_valid = 1'b1;
        adc1_data  = 12'hFFF;
        adc1_valid = 1'b1;
        expect_bytes(8'h41, 8'h23);
        expect_bytes(8'h5F, 8'hFF);
        expect_bytes(8'h20, 8'h3C);
        tick();
        din_tick   = 1'b0;
        adc0_valid = 1'b0;
        adc1_valid = 1'b0;
        wait_drain("prio_drain", 30);
        check_output("prio_ovr", overrun, 3'b000);

        $display("[TB] queue full stall in HDR");
        expect_bytes(8'h41, 8'h23);
        apply_stimulus(2'd1, 12'h123);
        tick();
        wq.fu_write = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("stall_pp", wq.pp_write, 1'b0);
        end
        wq.fu_write = 1'b0;
        tick();
        check_push("stall_hdr", 8'h41);
        tick();
        check_push("stall_pay", 8'h23);
        tick();
        check_output("stall_end_pp", wq.pp_write, 1'b0);

        $display("[TB] overrun with newest-wins buffer");
        wq.fu_write = 1'b1;
        expect_bytes(8'h44, 8'h56);
        expect_bytes(8'h50, 8'h02);
        apply_stimulus(2'd1, 12'h456);
        tick();
        apply_stimulus(2'd2, 12'h001);
        check_output("ovr_first", overrun, 3'b000);
        apply_stimulus(2'd2, 12'h002);
        check_output("ovr_set", overrun, 3'b100);
        wq.fu_write = 1'b0;
        wait_drain("ovr_drain", 30);
        check_output("ovr_sticky", overrun, 3'b100);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check_output("ovr_clear", overrun, 3'b000);

        // A second overrun arriving together with clr_ovr must still be flagged.
        wq.fu_write = 1'b1;
        expect_bytes(8'h47, 8'h89);
        expect_bytes(8'h5B, 8'hCD);
        apply_stimulus(2'd1, 12'h789);
        tick();
        apply_stimulus(2'd2, 12'h111);
        clr_ovr = 1'b1;
        apply_stimulus(2'd2, 12'hBCD);
        clr_ovr = 1'b0;
        check_output("ovr_set_wins", overrun, 3'b100);
        wq.fu_write = 1'b0;
        wait_drain("ovr2_drain", 30);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;

        $display("[TB] disabled sources");
        activemods = 5'b00110;
        base = push_count;
        apply_stimulus(2'd0, 12'h0AA);
        repeat (6) tick();
        check_output("dis_dig_count", push_count - base, 0);
        wq.fu_write = 1'b1;
        expect_bytes(8'h57, 8'h77);
        apply_stimulus(2'd2, 12'h777);
        tick();
        apply_stimulus(2'd1, 12'h321);
        activemods = 5'b00100;
        tick();
        activemods = 5'b00110;
        wq.fu_write = 1'b0;
        wait_drain("dis_drain", 30);
        repeat (4) tick();
        check_output("dis_adc0_count", push_count - base, 2);
        check_output("dis_ovr", overrun, 3'b000);

        $display("[TB] reset mid-packet");
        activemods = 5'b00010;
        base = push_count;
        sb.push_back(8'h4A);
        apply_stimulus(2'd1, 12'hABC);
        tick();
        tick();
        check_push("rst_hdr", 8'h4A);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("rst_pp", wq.pp_write, 1'b0);
        check_output("rst_out", wq.out_write, 8'h00);
        check_output("rst_ovr", overrun, 3'b000);
        repeat (5) tick();
        check_output("rst_count", push_count - base, 1);
        expect_bytes(8'h45, 8'hA5);
        apply_stimulus(2'd1, 12'h5A5);
        wait_drain("rst_fresh_drain", 20);

        check_output("final_sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/send_ins.md
Name: send_ins

Overview:
- Transmit-side packet encoder for the acquisition core.
- Collects ADC samples and digital-input snapshots, encodes each into a 2-byte packet, and pushes the bytes into the outbound write queue toward the host link.
- The header byte format mirrors the host command encoding: type in bits [7:5], channel in bit [4], sample MSBs in bits [3:0].
- Source enables come from the activemods vector produced by the command decoder.

Parameters:
- ANALOG_P, 3'b010, header type code for an analog sample packet.
- DIGITAL_P, 3'b001, header type code for a digital snapshot packet.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- activemods  in  5  source enables: [0] digital, [1] ADC0, [2] ADC1; [4:3] ignored.
- adc0_data  in  12  ADC0 sample.
- adc0_valid  in  1  1-cycle strobe: adc0_data is valid.
- adc1_data  in  12  ADC1 sample.
- adc1_valid  in  1  1-cycle strobe: adc1_data is valid.
- din  in  8  digital input lines.
- din_tick  in  1  1-cycle strobe: snapshot din.
- fu_write  in  1  write queue full.
- out_write  out  8  byte to queue (registered).
- pp_write  out  1  push strobe (registered); queue accepts out_write on each edge where pp_write=1.
- overrun  out  3  sticky overrun flags: [0] digital, [1] ADC0, [2] ADC1.
- clr_ovr  in  1  clears overrun.

Behaviour:
- Reset (rst=1 at an edge): pp_write=0, out_write=0, overrun=0, all pending flags/buffers cleared, FSM to IDLE. A reset mid-packet abandons the partial packet; no further bytes of it are pushed.
- Capture, per source S:
  - On an edge with strobe=1 and its enable bit=1: buffer_S <= data; pending_S <= 1.
  - If pending_S was already 1 and not being latched that edge: buffer is overwritten (newest wins) and overrun[S] <= 1.
  - Strobe with enable=0 is ignored.
  - Enable dropping to 0 clears pending_S on the next edge; a packet already latched still completes.
- Packet encoding:
  - ADCn: byte0 = {ANALOG_P, n, sample[11:8]}, byte1 = sample[7:0].
  - Digital: byte0 = {DIGITAL_P, 5'b0}, byte1 = din snapshot.
- FSM states: IDLE, HDR, PAY.
  - IDLE: if any pending, select by fixed priority ADC0 > ADC1 > digital. Latch byte0/byte1 into a 16-bit shift word, clear the selected pending flag, go to HDR. pp_write <= 0.
  - HDR: if fu_write=0, pp_write <= 1, out_write <= byte0, go to PAY. Otherwise pp_write <= 0 and stay.
  - PAY: if fu_write=0, pp_write <= 1, out_write <= byte1, go to IDLE. Otherwise pp_write <= 0 and stay.
  - Illegal state: go to IDLE.
- Flow control: fu_write is sampled on the same edge the push is registered. A full queue stalls indefinitely with no byte loss. Bytes are never reordered, and packets are never interleaved.
- Latency, empty queue: strobe at edge E0 gives pending at E0; latch at E1; header on out_write with pp_write=1 after E2; payload after E3; pp_write=0 after E4. Minimum of one non-push cycle between packets.
- Simultaneous strobe and latch of the same source: the latched value is the old buffer; the new value sets pending again; no overrun.
- Simultaneous strobe and clr_ovr: the set wins for that bit.
- Throughput: at most one packet every 3 cycles.

Test Plan:
1. Reset, then activemods=5'b00010 and adc0_valid with adc0_data=12'hA5C -> pushes 8'h4A then 8'h5C after E2/E3; pp_write high exactly 2 cycles; overrun=0.
2. adc0_valid, adc1_valid and din_tick on the same edge, all enabled, din=8'h3C, adc0=12'h123, adc1=12'hFFF -> byte order 8'h41, 8'h23, 8'h5F, 8'hFF, 8'h20, 8'h3C.
3. fu_write held high for 5 cycles starting in HDR -> pp_write stays 0, then 8'h41 and 8'h23 are pushed back to back after release; no byte lost or repeated.
4. With fu_write=1, two adc1_valid strobes (12'h001 then 12'h002) -> overrun[2]=1 and the packet carries 12'h002 (8'h50, 8'h02); a clr_ovr pulse then clears it.
5. din_tick with activemods[0]=0 -> no push; clearing activemods[1] while ADC0 is pending -> pending dropped, no packet.
6. rst asserted the cycle after the header push -> no payload byte; all outputs 0; a fresh packet afterwards is correct.
